xor_share_arbiter: RTL and testbench
====================================

# xor_share_arbiter

Round-robin arbiter and sequencer that shares one registered XOR datapath (`a ^ b`, `WIDTH` bits) between `NREQ` requesters. Each requester presents an operand pair with a valid/ready handshake. The arbiter grants one requester per cycle, captures the XOR result in a single output slot, and returns it tagged with the requester index over a valid/ready response channel. It sits between the client blocks and the XOR unit, replacing any direct client-side instantiation of that unit.

## Interface
Parameters:
- `NREQ`, 4: number of requesters; legal range 2..8.
- `WIDTH`, 8: operand and result width.
- `IDW`, `$clog2(NREQ)`: width of the response tag; derived, not overridden.

Ports:
- `clk`, input, 1: single clock; all logic is rising-edge.
- `rst_n`, input, 1: asynchronous, active-low reset. Assertion takes effect immediately; release is synchronous to `clk`.
- `req_valid`, input, NREQ: bit i means requester i presents operands.
- `req_ready`, output, NREQ: one-hot grant; bit i high means requester i's operands are accepted this cycle.
- `req_a`, input, NREQ*WIDTH: operand a; requester i occupies bits [i*WIDTH +: WIDTH].
- `req_b`, input, NREQ*WIDTH: operand b, packed the same way as `req_a`.
- `rsp_valid`, output, 1: the result slot holds a result.
- `rsp_ready`, input, 1: the consumer accepts the result.
- `rsp_data`, output, WIDTH: `a ^ b` of the accepted request.
- `rsp_id`, output, IDW: index of the requester that produced `rsp_data`.
- `stats_clr`, input, 1: synchronous clear of `op_count`.
- `op_count`, output, 16: number of completed operations (see Configuration).

## Operation
- State machine:
  - States: EMPTY (slot free) and FULL (slot holds an undelivered result).
  - EMPTY -> FULL on accept.
  - FULL -> EMPTY on `rsp_valid & rsp_ready` when no new accept happens that cycle.
  - FULL -> FULL on drain plus accept in the same cycle (back-to-back).
- Slot available this cycle: `avail = EMPTY | rsp_ready`.
- Grant rule:
  - When `avail` is high and any `req_valid` is set, exactly one `req_ready` bit goes high: the first valid requester searching upward from `ptr`, with wrap-around.
  - `req_ready` is combinational from `req_valid`, the state, `ptr` and `rsp_ready`.
  - When `avail` is low or no `req_valid` is set, `req_ready` is all zeros.
- Accept = `req_valid[g] & req_ready[g]`. On accept:
  - `rsp_data` <= `req_a[g] ^ req_b[g]`.
  - `rsp_id` <= g.
  - `ptr` <= (g+1) mod NREQ.
- `ptr` changes only on an accept; idle cycles do not rotate it.
- Requesters must hold `req_valid` and operands stable until granted. Deasserting `req_valid` before a grant is permitted and simply withdraws the request.
- While FULL and not drained, `rsp_data` and `rsp_id` hold stable.

## Timing
- Reset values:
  - State: EMPTY.
  - `ptr`: 0.
  - `rsp_valid`: 0.
  - `rsp_data`: 0.
  - `rsp_id`: 0.
  - `op_count`: 0.
  - `req_ready`: 0, because no request can be granted in reset.
- Latency: accept in cycle N gives `rsp_valid=1` in cycle N+1.
- Throughput: one operation per cycle while `rsp_ready` stays high.
- Reset asserted mid-operation: a pending result is discarded and `ptr` returns to 0.
- Simultaneous requests: only one is granted per cycle; the rest wait. With all requesters continuously valid, starvation is bounded to NREQ-1 grants.
- Wrap-around: when `ptr = NREQ-1` and requester NREQ-1 is idle, the search continues at index 0.

## Configuration
- `XOR_SHARE_ARBITER_STATS_EN` defined:
  - `op_count` increments by 1 on each response handshake (`rsp_valid & rsp_ready`).
  - It saturates at 0xFFFF.
  - `stats_clr` sets it to 0 on the next edge; if clear and handshake coincide, clear wins.
- Not defined:
  - `op_count` is tied to 0 and no counter flops exist.
  - `stats_clr` is ignored.
  - The port list is identical in both builds.

## Test plan
- Reset: hold `rst_n=0` with all `req_valid=1` -> `req_ready=0`, `rsp_valid=0`, `rsp_data=0`, `op_count=0`.
- Single request: requester 2 with a=0xA5, b=0x0F, `rsp_ready=1` -> `req_ready=4'b0100` in cycle N; in cycle N+1 `rsp_valid=1`, `rsp_data=0xAA`, `rsp_id=2`.
- Round-robin fairness: all four requesters valid, `rsp_ready=1` for 8 cycles -> grant order 0,1,2,3,0,1,2,3 and 8 results with matching ids.
- Backpressure: `rsp_ready=0` after the first accept -> `req_ready=0` and `rsp_data`/`rsp_id` stable every stalled cycle. Raising `rsp_ready` -> drain and next grant occur in the same cycle.
- Reset mid-operation: pulse `rst_n` low while FULL with `ptr=3` -> `rsp_valid` drops asynchronously; after release with requesters 0 and 3 valid, requester 0 is granted first.
- Stats build with the macro defined: 70000 handshakes -> `op_count=0xFFFF`. `stats_clr` coinciding with a handshake -> `op_count=0` next cycle. Without the macro -> `op_count=0` throughout.

Source files
------------

// File: rtl/xor_share_arbiter.sv
// Round-robin arbiter sharing one registered XOR slot among NREQ requesters.
// Optional op counter: define XOR_SHARE_ARBITER_STATS_EN.
module xor_share_arbiter #(
  parameter int NREQ = 4,
  parameter int WIDTH = 8,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_data,
  output logic [IDW-1:0]        rsp_id,
  input  logic                  stats_clr,
  output logic [15:0]           op_count
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t           state, state_n;
  logic [IDW-1:0]   ptr, gidx;
  logic [IDW:0]     sum;
  logic             found, avail, accept;
  logic [WIDTH-1:0] xres;

  always_comb begin
    found = 1'b0;
    gidx  = '0;
    sum   = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr} + (IDW+1)'(k);
      if (sum >= (IDW+1)'(NREQ))
        sum = sum - (IDW+1)'(NREQ);
      if (!found && req_valid[sum[IDW-1:0]]) begin
        found = 1'b1;
        gidx  = sum[IDW-1:0];
      end
    end
  end

  // nothing may be granted while reset is held
  assign avail  = (state == EMPTY) | rsp_ready;
  assign accept = avail & found & rst_n;

  always_comb begin
    req_ready = '0;
    if (accept)
      req_ready[gidx] = 1'b1;
  end

  always_comb begin
    xres = '0;
    for (int i = 0; i < NREQ; i++)
      if (gidx == IDW'(i))
        xres = req_a[i*WIDTH +: WIDTH] ^ req_b[i*WIDTH +: WIDTH];
  end

  always_comb begin
    state_n = state;
    unique case (state)
      EMPTY:   if (accept) state_n = FULL;
      FULL:    if (!accept && rsp_ready) state_n = EMPTY;
      default: state_n = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= EMPTY;
      ptr      <= '0;
      rsp_data <= '0;
      rsp_id   <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        rsp_data <= xres;
        rsp_id   <= gidx;
        ptr      <= (gidx == IDW'(NREQ-1)) ? '0 : gidx + 1'b1;
      end
    end
  end

  assign rsp_valid = (state == FULL);

`ifdef XOR_SHARE_ARBITER_STATS_EN
  logic [15:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (stats_clr)
      cnt <= '0;
    else if (rsp_valid && rsp_ready && cnt != 16'hFFFF)
      cnt <= cnt + 16'd1;
  end

  assign op_count = cnt;
`else
  logic unused_stats_clr;

  assign unused_stats_clr = stats_clr;
  assign op_count = '0;
`endif

endmodule

// File: tb/tb_xor_share_arbiter.sv
// Scoreboard bench for xor_share_arbiter: model predicts grants/results,
// monitor compares each presented response against the expected queue.
module tb_xor_share_arbiter;

  localparam int N = 4;
  localparam int W = 8;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready;
  logic [N*W-1:0] req_a, req_b;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [W-1:0]  rsp_data;
  logic [IW-1:0] rsp_id;
  logic          stats_clr;
  logic [15:0]   op_count;

  int n_cmp = 0;
  int n_bad = 0;

  logic [N-1:0] hs;

  bit         m_full;
  int         m_ptr;
  int         m_cnt;
  logic [W+IW-1:0] q[$];

  xor_share_arbiter #(.NREQ(N), .WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id),
    .stats_clr(stats_clr), .op_count(op_count)
  );

  always #5 clk = ~clk;

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference model: evaluated once per cycle, predicts the coming edge
  always @(negedge clk) begin
    int g, idx;
    bit av, rhs;
    logic [31:0] exp_cnt;
    if (!rst_n) begin
      m_full = 0;
      m_ptr = 0;
      m_cnt = 0;
      q.delete();
    end else begin
      g = -1;
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (g < 0 && req_valid[idx]) g = idx;
      end
      av = !m_full || rsp_ready;
`ifdef XOR_SHARE_ARBITER_STATS_EN
      exp_cnt = m_cnt;
`else
      exp_cnt = 0;
`endif
      check("req_ready", req_ready, (av && g >= 0) ? (32'd1 << g) : 32'd0);
      check("rsp_valid", rsp_valid, m_full);
      check("op_count", op_count, exp_cnt);
      rhs = m_full && rsp_ready;
      if (stats_clr) m_cnt = 0;
      else if (rhs && m_cnt < 65535) m_cnt++;
      if (av && g >= 0) begin
        q.push_back({req_a[g*W +: W] ^ req_b[g*W +: W], IW'(g)});
        m_ptr = (g + 1) % N;
        m_full = 1;
      end else if (rhs) begin
        m_full = 0;
      end
    end
  end

  // monitor: every presented response must match the oldest expectation
  always @(negedge clk) begin
    #1;
    if (rst_n && rsp_valid) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL rsp_unexpected: got id %0d data %0h with none expected",
                 rsp_id, rsp_data);
      end else begin
        check("rsp_data", rsp_data, q[0][W+IW-1:IW]);
        check("rsp_id", rsp_id, q[0][IW-1:0]);
        if (rsp_ready) void'(q.pop_front());
      end
    end
  end

  task automatic step();
    @(negedge clk);
    hs = req_valid & req_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic refresh(logic [N-1:0] m);
    for (int i = 0; i < N; i++)
      if (m[i]) begin
        req_a[i*W +: W] = W'($urandom);
        req_b[i*W +: W] = W'($urandom);
      end
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = '1;
    rsp_ready = 1'b1;
    stats_clr = 1'b0;
    hs = '0;
    refresh('1);
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_op_count", op_count, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      step();
      check("rr_grant", hs, 32'd1 << (i % N));
      refresh(hs);
    end

    req_valid = 4'b0100;
    req_a[2*W +: W] = 8'hA5;
    req_b[2*W +: W] = 8'h0F;
    step();
    check("single_grant", hs, 4'b0100);
    req_valid = 4'b0001;
    rsp_ready = 1'b0;
    check("single_valid", rsp_valid, 1);
    check("single_data", rsp_data, 8'hAA);
    check("single_id", rsp_id, 2);
    repeat (3) begin
      step();
      check("stall_grant", hs, 0);
      check("stall_data", rsp_data, 8'hAA);
      check("stall_id", rsp_id, 2);
    end

    #1 rst_n = 1'b0;
    #1 check("async_rst_valid", rsp_valid, 0);
    req_valid = 4'b1001;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_grant", req_ready, 4'b0001);
    @(posedge clk);
    #1;
    req_valid = 4'b1000;

    for (int c = 0; c < 2000; c++) begin
      step();
      for (int i = 0; i < N; i++) begin
        if (hs[i]) begin
          req_valid[i] = 1'($urandom_range(0, 1));
          refresh(N'(1) << i);
        end else if (!req_valid[i]) begin
          req_valid[i] = ($urandom_range(0, 2) == 0);
          refresh(N'(1) << i);
        end else if ($urandom_range(0, 15) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      stats_clr = ($urandom_range(0, 49) == 0);
    end

    stats_clr = 1'b0;
    rsp_ready = 1'b1;
    req_valid = '1;
`ifdef XOR_SHARE_ARBITER_STATS_EN
    for (int c = 0; c < 70000; c++) begin
      step();
      refresh(hs);
    end
    check("op_saturate", op_count, 16'hFFFF);
    stats_clr = 1'b1;
    step();
    stats_clr = 1'b0;
    check("op_clr_wins", op_count, 0);
`else
    repeat (20) begin
      step();
      refresh(hs);
    end
    check("op_tied_zero", op_count, 0);
`endif
    req_valid = '0;
    repeat (4) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
